// File: rtl/g11_pkg.sv
// Shared definitions for the serial transmitter slice.
//   state_e   : FSM encoding (StIdle=00, StShift=01, StGap=10)
//   clog2     : ceiling log2, for sizing counters from elaboration-time constants
//   cnt_width : clog2 clamped to at least one bit, for counters that may hold only 0
package g11_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StGap   = 2'b10
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (clog2(max_count) > 0) ? clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/seq_bit_counter.sv
// Loadable down-counter with a zero flag. It saturates at zero, so a decrement
// request while already at zero has no effect.
//   clk_i      : clock, rising edge
//   rst_ni     : active-low reset, synchronous (sampled on clk_i)
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one when non-zero
//   zero_o     : count is zero
module seq_bit_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/seq_serializer.sv
// Serial bit-stream transmitter: accepts a WIDTH-bit word on start && ready and
// shifts it out MSB-first, one bit per clock, with a per-bit valid flag.
// GAP_CYCLES idle cycles follow each word; with GAP_CYCLES == 0 a word accepted
// during the last bit streams out with no hole in x_valid.
// Optional feature macro: SEQ_SERIALIZER_PARITY_EN appends an even-parity bit
// (XOR of the captured word) after the LSB, making the frame WIDTH+1 bits.
//   clk     : clock, rising edge
//   reset   : active-low reset, synchronous; has priority over start
//   start   : request to send data
//   data    : word to send, captured on the accepting edge
//   ready   : a word can be accepted this cycle
//   x       : serial data, registered (0 whenever x_valid is 0)
//   x_valid : x carries a frame bit, registered
//   done    : high while the final frame bit is on x
module seq_serializer
  import g11_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

`ifdef SEQ_SERIALIZER_PARITY_EN
  localparam int unsigned Frame = WIDTH + 1;
`else
  localparam int unsigned Frame = WIDTH;
`endif
  localparam int unsigned     BitW    = clog2(Frame);
  localparam int unsigned     GapW    = cnt_width(GAP_CYCLES);
  localparam logic [BitW-1:0] BitLoad = BitW'(Frame - 1);
  localparam logic [GapW-1:0] GapLoad = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit              HasGap  = (GAP_CYCLES > 0);

  state_e           state_d, state_q;
  logic [Frame-1:0] shift_d, shift_q;
  logic             x_valid_d, x_valid_q;
  logic [Frame-1:0] frame_word;
  logic             accept;
  logic             bit_load, bit_dec, bit_zero;
  logic             gap_load, gap_dec, gap_zero;

`ifdef SEQ_SERIALIZER_PARITY_EN
  assign frame_word = {data, ^data};
`else
  assign frame_word = data;
`endif

  assign ready  = (state_q == StIdle) || ((state_q == StShift) && bit_zero && !HasGap);
  assign done   = (state_q == StShift) && bit_zero;
  assign accept = start && ready;

  // The bit on x is always the shift register MSB, so x is a plain flop output.
  assign x       = shift_q[Frame-1];
  assign x_valid = x_valid_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    x_valid_d = x_valid_q;
    bit_load  = 1'b0;
    bit_dec   = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    // accept is only possible in IDLE or on the last bit without a gap; both load.
    if (accept) begin
      state_d   = StShift;
      shift_d   = frame_word;
      x_valid_d = 1'b1;
      bit_load  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StShift: begin
          if (!bit_zero) begin
            shift_d = shift_q << 1;
            bit_dec = 1'b1;
          end else begin
            state_d   = HasGap ? StGap : StIdle;
            gap_load  = HasGap;
            shift_d   = '0;
            x_valid_d = 1'b0;
          end
        end
        StGap: begin
          if (gap_zero) begin
            state_d = StIdle;
          end else begin
            gap_dec = 1'b1;
          end
        end
        default: begin
          state_d   = StIdle;
          shift_d   = '0;
          x_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      x_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      x_valid_q <= x_valid_d;
    end
  end

  // Bits remaining after the one currently on x.
  seq_bit_counter #(
    .Width(BitW)
  ) u_bit_cnt (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (bit_load),
    .load_val_i(BitLoad),
    .dec_i     (bit_dec),
    .zero_o    (bit_zero)
  );

  // Gap cycles remaining after the current one.
  seq_bit_counter #(
    .Width(GapW)
  ) u_gap_cnt (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (gap_load),
    .load_val_i(GapLoad),
    .dec_i     (gap_dec),
    .zero_o    (gap_zero)
  );

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
Serial bit-stream transmitter. It is the source-side counterpart of the serial sequence-detector FSMs.
- Accepts a WIDTH-bit word through a start/ready handshake.
- Shifts the word out MSB-first on a single serial line, one bit per clock, with a per-bit valid flag.
- Pulses done on the final bit.
- Drives detector benches and any downstream serial consumer.

Parameters:
WIDTH, 4, bits per word (minimum 2)
GAP_CYCLES, 1, idle cycles (x=0, x_valid=0) inserted after each word; 0 = back-to-back streaming

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset; sampled on posedge clk
start  input  1  request to send data; accepted when start && ready at posedge clk
data  input  WIDTH  word to transmit; captured on the accepting edge
ready  output  1  block can accept a word this cycle
x  output  1  serial data, MSB first, registered
x_valid  output  1  x carries a frame bit this cycle, registered
done  output  1  one-cycle pulse, high while the final frame bit is on x

Behaviour:
- Reset: on posedge clk with reset==0, the following all hold from the next cycle.
  - state=IDLE, shift register=0, bit counter=0, gap counter=0.
  - Outputs: x=0, x_valid=0, done=0, ready=1.
  - Reset has priority over start.
- States:
  - IDLE: waiting for a word.
  - SHIFT: presenting frame bits.
  - GAP: inter-word spacing.
- IDLE:
  - ready=1.
  - On start && ready, on the same edge: capture data; load x<=data[WIDTH-1]; x_valid<=1; counter<=FRAME-1; go to SHIFT.
  - Latency: first bit visible one clock after the accepting edge.
- SHIFT:
  - Each edge with counter>0: shift left, present the next bit, decrement the counter.
  - done is combinational, =(state==SHIFT && counter==0).
  - On the edge leaving the last bit:
    - Go to GAP if GAP_CYCLES>0.
    - Otherwise go to IDLE, or reload if a start was accepted.
- GAP:
  - x=0, x_valid=0, ready=0 for exactly GAP_CYCLES cycles, then IDLE.
- Ready rule: ready = (state==IDLE) || (state==SHIFT && counter==0 && GAP_CYCLES==0).
  - Back-to-back acceptance during the last bit gives a gapless stream: next word's MSB follows the previous LSB with x_valid continuously 1.
- start while ready==0: ignored; data not captured, no side effects.
- data may change freely except on the accepting edge.
- Frame length FRAME = WIDTH (WIDTH+1 with the parity option).
- Counter width = clog2(FRAME).
- x_valid==0 implies x==0.
- Reset mid-word: frame aborted; partial output is not completed; no done pulse is generated.

Optional Feature:
SEQ_SERIALIZER_PARITY_EN
- Defined:
  - An even-parity bit (XOR of data) is appended after the LSB; FRAME=WIDTH+1.
  - done is high on the parity-bit cycle.
  - Parity is computed from the captured word, not live data.
- Undefined:
  - FRAME=WIDTH; no parity logic present.

Decomposition:
- Shared package g11_pkg holds:
  - State encodings: IDLE=2'b00, SHIFT=2'b01, GAP=2'b10.
  - A clog2 constant function for counter sizing.
- One natural sub-module, seq_bit_counter:
  - Loadable down-counter with a zero flag.
  - Used for both the bit counter and the gap counter, instantiated twice.
- FSM and shift register stay in seq_serializer.

Test Plan:
1. reset=0 for 2 cycles, start=1 held -> x=0, x_valid=0, done=0, ready=1; nothing captured.
2. WIDTH=4, GAP=1, start with data=4'b1101 -> x=1,1,0,1 on cycles 1-4 with x_valid=1, done only on cycle 4; cycle 5 x_valid=0, ready=0; cycle 6 ready=1.
3. GAP=0, data=4'b1101 then 4'b1011 accepted on last-bit cycle -> 8 contiguous valid bits 1,1,0,1,1,0,1,1; done on bits 4 and 8; a 1101 detector fed x flags twice.
4. Mid-word start with data=4'b0000 -> ignored; original word completes unchanged; no extra frame.
5. reset=0 during bit 2 of 4'b1101 -> next cycle x=0, x_valid=0, ready=1, no done; a new start sends a full fresh frame.
6. SEQ_SERIALIZER_PARITY_EN defined, data=4'b1101 -> x=1,1,0,1,1, done on 5th bit; data=4'b1001 -> parity bit 0.
